// File: rtl/demux1to2_steer_ctrl.sv
// Credit-based steering controller for the router's 1-to-2 flit demux: a one-entry
// holding register, per-branch credit counters and stall-limited deflection.
module demux1to2_steer_ctrl #(
   parameter int unsigned FLIT_W      = 64,
   parameter int unsigned CREDIT_MAX  = 4,
   parameter int unsigned STALL_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [FLIT_W-1:0] in_flit,
   input  logic              in_dst,
   output logic              in_ready,
   output logic [FLIT_W-1:0] demux_data,
   output logic              demux_sel,
   output logic              a_valid,
   output logic              b_valid,
   input  logic              a_credit_ret,
   input  logic              b_credit_ret,
   output logic              deflect,
   output logic              credit_err
);
   localparam logic [3:0] CRED_FULL = 4'(CREDIT_MAX);
   localparam logic [4:0] STALL_LIM = 5'(STALL_LIMIT);
   localparam logic [3:0] STALL_SAT = 4'd15;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t            state_r, state_s;
   logic [FLIT_W-1:0] hold_flit_r;
   logic              hold_dst_r;
   logic [3:0]        cred_a_r, cred_b_r, cred_a_s, cred_b_s;
   logic [3:0]        stall_cnt_r, stall_cnt_s;
   logic              credit_err_r, err_a_s, err_b_s;
   logic              hold_v_s, stalled_s, defl_s, eff_dst_s, fire_s, accept_s;
   logic [3:0]        cred_req_s, cred_oth_s, cred_eff_s;
   logic              send_a_s, send_b_s;

   // Returns {overflow, next credit}; a send and a return in one cycle cancel out.
   function automatic logic [4:0] cred_step(input logic [3:0] cur, input logic send, input logic ret);
      logic [3:0] nxt;
      logic       err;
      nxt = cur;
      err = 1'b0;
      case ({send, ret})
         2'b10:   nxt = (cur != 4'd0) ? cur - 4'd1 : cur;
         2'b01:   if (cur == CRED_FULL) err = 1'b1; else nxt = cur + 4'd1;
         default: nxt = cur;
      endcase
      return {err, nxt};
   endfunction

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= EMPTY;
      else        state_r <= state_s;
   end

   // Steering decision: deflect only a starved flit when the other branch has room
   always_comb begin
      hold_v_s   = (state_r == FULL);
      stalled_s  = (STALL_LIM != 5'd0) && ({1'b0, stall_cnt_r} >= STALL_LIM);
      cred_req_s = hold_dst_r ? cred_b_r : cred_a_r;
      cred_oth_s = hold_dst_r ? cred_a_r : cred_b_r;
      defl_s     = hold_v_s && stalled_s && (cred_req_s == 4'd0) && (cred_oth_s != 4'd0);
      eff_dst_s  = hold_dst_r ^ defl_s;
      cred_eff_s = eff_dst_s ? cred_b_r : cred_a_r;
      fire_s     = hold_v_s && (cred_eff_s != 4'd0);
      accept_s   = in_valid && (!hold_v_s || fire_s);
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         EMPTY:   state_s = accept_s ? FULL : EMPTY;
         FULL:    state_s = (fire_s && !accept_s) ? EMPTY : FULL;
         default: state_s = EMPTY;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready   = !hold_v_s || fire_s;
      demux_sel  = eff_dst_s;
      demux_data = hold_flit_r;
      a_valid    = fire_s && !eff_dst_s;
      b_valid    = fire_s && eff_dst_s;
      deflect    = fire_s && defl_s;
      credit_err = credit_err_r;
   end

   // Next credit and stall-counter values
   always_comb begin
      send_a_s = fire_s && !eff_dst_s;
      send_b_s = fire_s && eff_dst_s;
      {err_a_s, cred_a_s} = cred_step(cred_a_r, send_a_s, a_credit_ret);
      {err_b_s, cred_b_s} = cred_step(cred_b_r, send_b_s, b_credit_ret);
      if (!hold_v_s || fire_s)            stall_cnt_s = 4'd0;
      else if (stall_cnt_r != STALL_SAT)  stall_cnt_s = stall_cnt_r + 4'd1;
      else                                stall_cnt_s = stall_cnt_r;
   end

   // Holding register, credits, stall counter and sticky error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_flit_r  <= {FLIT_W{1'b0}};
         hold_dst_r   <= 1'b0;
         cred_a_r     <= CRED_FULL;
         cred_b_r     <= CRED_FULL;
         stall_cnt_r  <= 4'd0;
         credit_err_r <= 1'b0;
      end else begin
         if (accept_s) begin
            hold_flit_r <= in_flit;
            hold_dst_r  <= in_dst;
         end
         cred_a_r     <= cred_a_s;
         cred_b_r     <= cred_b_s;
         stall_cnt_r  <= stall_cnt_s;
         credit_err_r <= credit_err_r | err_a_s | err_b_s;
      end
   end
endmodule

// File: tb/tb_demux1to2_steer_ctrl.sv
// Directed bench for demux1to2_steer_ctrl: cycle-level reference model with a flit
// scoreboard, plus hand-computed expectations along the directed sequence.
module tb_demux1to2_steer_ctrl;
   localparam int FW   = 64;
   localparam int CMAX = 4;
   localparam int SLIM = 8;
   localparam logic [FW-1:0] B1 = 64'h1111_0000_0000_0000;
   localparam logic [FW-1:0] B2 = 64'h2222_0000_0000_0000;
   localparam logic [FW-1:0] G  = 64'h3333_0000_0000_00A5;
   localparam logic [FW-1:0] H  = 64'h4444_0000_0000_0000;
   localparam logic [FW-1:0] J  = 64'h5555_0000_0000_0000;
   localparam logic [FW-1:0] K  = 64'h6666_0000_0000_0000;

   logic          clk = 1'b0;
   logic          rst_n, in_valid, in_dst, a_credit_ret, b_credit_ret;
   logic [FW-1:0] in_flit;
   logic          in_ready, demux_sel, a_valid, b_valid, deflect, credit_err;
   logic [FW-1:0] demux_data;
   logic          z_ready, z_sel, z_a, z_b, z_defl, z_err;
   logic [FW-1:0] z_data;

   int vectors = 0;
   int miscompares = 0;

   int            m_ca, m_cb, m_stall, m_dst;
   bit            m_held, m_err;
   logic [FW-1:0] m_flit;
   logic [FW-1:0] exp_q[$];

   demux1to2_steer_ctrl #(.FLIT_W(FW), .CREDIT_MAX(CMAX), .STALL_LIMIT(SLIM)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_flit(in_flit), .in_dst(in_dst),
      .in_ready(in_ready), .demux_data(demux_data), .demux_sel(demux_sel),
      .a_valid(a_valid), .b_valid(b_valid), .a_credit_ret(a_credit_ret),
      .b_credit_ret(b_credit_ret), .deflect(deflect), .credit_err(credit_err));

   demux1to2_steer_ctrl #(.FLIT_W(FW), .CREDIT_MAX(CMAX), .STALL_LIMIT(0)) dut_nodefl (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_flit(in_flit), .in_dst(in_dst),
      .in_ready(z_ready), .demux_data(z_data), .demux_sel(z_sel),
      .a_valid(z_a), .b_valid(z_b), .a_credit_ret(a_credit_ret),
      .b_credit_ret(b_credit_ret), .deflect(z_defl), .credit_err(z_err));

   always #5 clk = ~clk;

   task automatic check1(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkw(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic d, input logic [FW-1:0] f,
                        input logic ra, input logic rb);
      in_valid = v; in_dst = d; in_flit = f; a_credit_ret = ra; b_credit_ret = rb;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: predict this cycle's outputs, then advance on the inputs sampled next edge
   always @(negedge clk) begin
      automatic int go, cr, co, nca, ncb;
      automatic bit dfl, snd, sa, sbr, ne;
      if (!rst_n) begin
         check1("rst_in_ready", in_ready, 1'b1);
         check1("rst_a_valid", a_valid, 1'b0);
         check1("rst_b_valid", b_valid, 1'b0);
         check1("rst_demux_sel", demux_sel, 1'b0);
         checkw("rst_demux_data", demux_data, {FW{1'b0}});
         check1("rst_deflect", deflect, 1'b0);
         check1("rst_credit_err", credit_err, 1'b0);
         m_held <= 1'b0; m_flit <= {FW{1'b0}}; m_dst <= 0;
         m_ca <= CMAX; m_cb <= CMAX; m_stall <= 0; m_err <= 1'b0;
         exp_q.delete();
      end else begin
         cr  = (m_dst == 1) ? m_cb : m_ca;
         co  = (m_dst == 1) ? m_ca : m_cb;
         dfl = m_held && (SLIM != 0) && (m_stall >= SLIM) && (cr == 0) && (co > 0);
         go  = dfl ? 1 - m_dst : m_dst;
         snd = m_held && (((go == 1) ? m_cb : m_ca) > 0);
         sa  = snd && (go == 0);
         sbr = snd && (go == 1);
         check1("m_in_ready", in_ready, !m_held || snd);
         check1("m_a_valid", a_valid, sa);
         check1("m_b_valid", b_valid, sbr);
         check1("m_demux_sel", demux_sel, go == 1);
         checkw("m_demux_data", demux_data, m_flit);
         check1("m_deflect", deflect, snd && dfl);
         check1("m_credit_err", credit_err, m_err);
         if (a_valid || b_valid) begin
            check1("sb_has_flit", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) checkw("sb_order", demux_data, exp_q.pop_front());
         end
         if (in_valid && in_ready) exp_q.push_back(in_flit);
         nca = m_ca; ncb = m_cb; ne = m_err;
         if (sa && !a_credit_ret) nca = m_ca - 1;
         else if (a_credit_ret && !sa) begin
            if (m_ca == CMAX) ne = 1'b1; else nca = m_ca + 1;
         end
         if (sbr && !b_credit_ret) ncb = m_cb - 1;
         else if (b_credit_ret && !sbr) begin
            if (m_cb == CMAX) ne = 1'b1; else ncb = m_cb + 1;
         end
         m_ca <= nca; m_cb <= ncb; m_err <= ne;
         m_stall <= (!m_held || snd) ? 0 : ((m_stall < 15) ? m_stall + 1 : 15);
         if (in_valid && (!m_held || snd)) begin
            m_held <= 1'b1; m_flit <= in_flit; m_dst <= in_dst ? 1 : 0;
         end else if (snd) m_held <= 1'b0;
         else              m_held <= m_held;
      end
   end

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, {FW{1'b0}}, 1'b0, 1'b0);
      check1("reset_in_ready", in_ready, 1'b1);
      check1("reset_a_valid", a_valid, 1'b0);
      checkw("reset_data", demux_data, {FW{1'b0}});
      tick(); tick();
      rst_n = 1'b1;

      // Alternating stream with full credits
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, i[0], B1 + 64'(i), 1'b0, 1'b0);
         check1("t1_ready", in_ready, 1'b1);
         check1("t1_a", a_valid, (i % 2) == 1);
         check1("t1_b", b_valid, (i > 0) && ((i % 2) == 0));
         if (i > 0) checkw("t1_data", demux_data, B1 + 64'(i - 1));
         tick();
      end
      drive(1'b1, 1'b0, B1 + 64'd6, 1'b0, 1'b0);
      check1("t1_last_b", b_valid, 1'b1);
      check1("t1_last_sel", demux_sel, 1'b1);
      tick();
      drive(1'b1, 1'b0, B1 + 64'd7, 1'b0, 1'b0);
      check1("t1_creda_one", a_valid, 1'b1);
      tick();
      drive(1'b0, 1'b0, {FW{1'b0}}, 1'b0, 1'b0);
      check1("t1_creda_zero", a_valid, 1'b0);
      check1("t1_blocked_ready", in_ready, 1'b0);
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;

      // Exhaust branch A credits, then release with one return
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, B2 + 64'(i), 1'b0, 1'b0);
         check1("t2_ready", in_ready, 1'b1);
         check1("t2_a", a_valid, i > 0);
         tick();
      end
      drive(1'b0, 1'b0, {FW{1'b0}}, 1'b0, 1'b0);
      check1("t2_held_a", a_valid, 1'b0);
      check1("t2_held_ready", in_ready, 1'b0);
      checkw("t2_held_data", demux_data, B2 + 64'd4);
      tick();
      drive(1'b0, 1'b0, {FW{1'b0}}, 1'b1, 1'b0);
      check1("t2_ret_cycle_a", a_valid, 1'b0);
      tick();
      drive(1'b0, 1'b0, {FW{1'b0}}, 1'b0, 1'b0);
      check1("t2_release_a", a_valid, 1'b1);
      checkw("t2_release_data", demux_data, B2 + 64'd4);
      tick();

      // Deflection after the stall limit; the no-deflect instance keeps holding
      drive(1'b1, 1'b0, G, 1'b0, 1'b0);
      check1("t3_accept", in_ready, 1'b1);
      tick();
      for (int k = 1; k <= 8; k++) begin
         drive(1'b0, 1'b0, {FW{1'b0}}, 1'b0, 1'b0);
         check1("t3_stall_a", a_valid, 1'b0);
         check1("t3_stall_b", b_valid, 1'b0);
         check1("t3_stall_ready", in_ready, 1'b0);
         tick();
      end
      drive(1'b0, 1'b0, {FW{1'b0}}, 1'b0, 1'b0);
      check1("t3_defl_b", b_valid, 1'b1);
      check1("t3_defl_flag", deflect, 1'b1);
      check1("t3_defl_sel", demux_sel, 1'b1);
      checkw("t3_defl_data", demux_data, G);
      tick();
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, {FW{1'b0}}, 1'b0, 1'b0);
         check1("t3_nodefl_a", z_a, 1'b0);
         check1("t3_nodefl_b", z_b, 1'b0);
         check1("t3_nodefl_ready", z_ready, 1'b0);
         check1("t3_nodefl_sel", z_sel, 1'b0);
         check1("t3_nodefl_flag", z_defl, 1'b0);
         check1("t3_nodefl_err", z_err, 1'b0);
         checkw("t3_nodefl_data", z_data, G);
         tick();
      end

      // Simultaneous send and return on A with credA=2
      drive(1'b0, 1'b0, {FW{1'b0}}, 1'b1, 1'b0); tick();
      drive(1'b0, 1'b0, {FW{1'b0}}, 1'b1, 1'b0); tick();
      drive(1'b1, 1'b0, H, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b0, {FW{1'b0}}, 1'b1, 1'b0);
      check1("t4_send", a_valid, 1'b1);
      tick();
      drive(1'b1, 1'b0, H + 64'd1, 1'b0, 1'b0);
      check1("t4_no_err", credit_err, 1'b0);
      tick();
      drive(1'b1, 1'b0, H + 64'd2, 1'b0, 1'b0);
      check1("t4_cred2_first", a_valid, 1'b1);
      tick();
      drive(1'b1, 1'b0, H + 64'd3, 1'b0, 1'b0);
      check1("t4_cred2_second", a_valid, 1'b1);
      tick();
      drive(1'b0, 1'b0, {FW{1'b0}}, 1'b1, 1'b0);
      check1("t4_cred2_exhausted", a_valid, 1'b0);
      check1("t4_err_still_clear", credit_err, 1'b0);
      tick();

      // Reset with a flit held and credA=1
      drive(1'b1, 1'b0, J, 1'b1, 1'b0);
      check1("t6_prior_send", a_valid, 1'b1);
      tick();
      drive(1'b0, 1'b0, {FW{1'b0}}, 1'b0, 1'b0);
      check1("t6_held_sending", a_valid, 1'b1);
      checkw("t6_held_data", demux_data, J);
      rst_n = 1'b0;
      #1;
      check1("t6_rst_a", a_valid, 1'b0);
      check1("t6_rst_b", b_valid, 1'b0);
      check1("t6_rst_ready", in_ready, 1'b1);
      tick(); tick();
      rst_n = 1'b1;

      // Overflowing return sets the sticky error; credits stay at max
      drive(1'b0, 1'b0, {FW{1'b0}}, 1'b1, 1'b0);
      check1("t5_err_before", credit_err, 1'b0);
      tick();
      drive(1'b0, 1'b0, {FW{1'b0}}, 1'b0, 1'b0);
      check1("t5_err_set", credit_err, 1'b1);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, K + 64'(i), 1'b0, 1'b0);
         check1("t5_a", a_valid, i > 0);
         check1("t5_err_sticky", credit_err, 1'b1);
         if (i > 0) checkw("t5_data", demux_data, K + 64'(i - 1));
         tick();
      end
      drive(1'b0, 1'b0, {FW{1'b0}}, 1'b0, 1'b0);
      check1("t5_credmax_held", a_valid, 1'b0);
      check1("t5_credmax_ready", in_ready, 1'b0);
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/demux1to2_steer_ctrl.md
Name: demux1to2_steer_ctrl

Overview:
Credit-based flow controller that sequences the router's 1-to-2 flit demux. It accepts one flit per cycle from the upstream stage into a one-entry holding register and drives the demux select and datapath. It raises a valid strobe on exactly one output branch, A or B, only when that branch's downstream buffer has credit. If the target branch stays starved, the flit is deflected to the other branch after a programmable stall limit, consistent with the router's deflection policy.

Parameters:
FLIT_W, 64, flit width incl. header; instantiated with `IN_ROUTER_SIZE
CREDIT_MAX, 4, downstream buffer depth per branch (1..15)
STALL_LIMIT, 8, consecutive blocked cycles before deflection; 0 = deflection disabled

Ports:
clk  in  1  router clock
rst_n  in  1  asynchronous reset, active low
in_valid  in  1  upstream flit present
in_flit  in  FLIT_W  upstream flit
in_dst  in  1  requested branch: 0 = A, 1 = B
in_ready  out  1  holding register can accept this cycle
demux_data  out  FLIT_W  held flit, drives demux dataIn
demux_sel  out  1  effective branch, drives demux sel
a_valid  out  1  flit on branch A valid this cycle
b_valid  out  1  flit on branch B valid this cycle
a_credit_ret  in  1  one-cycle pulse: branch A freed one slot
b_credit_ret  in  1  one-cycle pulse: branch B freed one slot
deflect  out  1  current send goes to non-requested branch
credit_err  out  1  sticky: credit returned while counter already at CREDIT_MAX

Behaviour:
- Reset (async assert, sync deassert use): hold_v=0, hold_flit=0, hold_dst=0, credA=credB=CREDIT_MAX, stall_cnt=0, credit_err=0. Outputs: in_ready=1, a_valid=b_valid=0, demux_sel=0, demux_data=0, deflect=0.
- Holding register:
  - Loads on accept = in_valid & in_ready.
  - in_ready = !hold_v | fire, giving full throughput with pass-through on send.
  - Latency is 1 cycle from accept to earliest send.
- Credit counters: width 4, saturate at 0 and CREDIT_MAX.
- Deflection decision (combinational):
  - stalled = (STALL_LIMIT!=0) & (stall_cnt>=STALL_LIMIT).
  - cred_req = credit of hold_dst branch; cred_oth = credit of the other branch.
  - defl = hold_v & stalled & (cred_req==0) & (cred_oth!=0).
  - eff_dst = hold_dst ^ defl.
- Outputs (combinational from registers):
  - demux_sel = eff_dst.
  - demux_data = hold_flit.
  - fire = hold_v & (credit[eff_dst]!=0).
  - a_valid = fire & !eff_dst; b_valid = fire & eff_dst.
  - deflect = fire & defl.
  - Downstream must capture on valid; there is no downstream ready.
- Credit update per branch per cycle:
  - Decrement on that branch's valid; increment on that branch's credit_ret.
  - Both in the same cycle: no change.
  - Return while at CREDIT_MAX with no same-cycle send: counter unchanged, credit_err set (cleared only by reset).
- stall_cnt:
  - Cleared on fire, or when hold_v=0.
  - Otherwise increments while hold_v & !fire, saturating at 15.
  - A new flit loaded in the same cycle as fire starts with stall_cnt=0.
- State machine, two states:
  - EMPTY (hold_v=0): on accept -> FULL.
  - FULL (hold_v=1): fire & accept -> FULL with the new flit; fire & !accept -> EMPTY; !fire -> FULL, hold_flit stable.
- A valid strobe is never asserted on both branches in one cycle.
- A flit is never dropped or duplicated.
- Reset mid-operation: the held flit is discarded and credits are restored to CREDIT_MAX. The downstream side is reset concurrently.

Test Plan:
1. Stream 6 flits with in_dst alternating 0,1,0,1,0,1, in_valid=1 every cycle, credits full. Expected: in_ready=1 throughout, one send per cycle starting 1 cycle after the first accept, a_valid/b_valid alternating, demux_sel matching in_dst, credA=credB=1 at the end.
2. Send 5 flits to A with no credit returns (CREDIT_MAX=4). Expected: 4 a_valid pulses, then flit 5 held with in_ready=0. One a_credit_ret pulse releases flit 5 on the next cycle.
3. credA=0, credB=4, one flit held with in_dst=0, STALL_LIMIT=8. Expected: no send for 8 cycles, then on the 9th cycle b_valid=1, deflect=1, demux_sel=1, credB becomes 3. With STALL_LIMIT=0 the flit stays held indefinitely.
4. credA=2; in the same cycle a_valid fires and a_credit_ret pulses. Expected: credA stays 2 and credit_err stays 0.
5. credA=4 with an a_credit_ret pulse and no send. Expected: credit_err=1 and remains set; credA stays 4.
6. Assert rst_n low mid-stream with a flit held and credA=1. Expected: immediately a_valid=b_valid=0 and in_ready=1; after release credA=credB=4 and the next accepted flit sends normally.
